fwuart_tx_fifo: RTL and testbench
=================================

Name: fwuart_tx_fifo

Overview:
Synchronous byte FIFO placed directly upstream of fwuart_tx. It accepts bytes from any ready/valid producer (host BFM, bus bridge) on a target-side interface. It replays them in order on an initiator-side interface that connects to fwuart_tx's t_ port. This decouples bursty producers from the slow serial line and exposes fill level and watermark status for software or flow control.

Parameters:
DATA_WIDTH, 8, width of each entry
DEPTH_LOG2, 4, log2 of entry count (DEPTH = 2**DEPTH_LOG2, default 16)
HIWAT, 12, level at or above which hi_wat asserts (1..DEPTH)

Ports:
clock  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
t_dat  input  DATA_WIDTH  write data from producer
t_valid  input  1  producer has data
t_ready  output  1  FIFO can accept (not full)
i_dat  output  DATA_WIDTH  head-of-FIFO data to fwuart_tx
i_valid  output  1  head entry valid
i_ready  input  1  fwuart_tx accepts head entry
level  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH
hi_wat  output  1  level >= HIWAT
empty  output  1  level == 0
flush  input  1  synchronous clear of contents (not of config)

Behaviour:
- Handshakes: push = t_valid & t_ready; pop = i_valid & i_ready. Transfers occur on the clock edge where the respective product is 1.
- Storage: DEPTH x DATA_WIDTH array. Write ptr wp and read ptr rp are DEPTH_LOG2 bits and wrap modulo DEPTH. level is a separate DEPTH_LOG2+1-bit counter.
- t_ready = (level != DEPTH), combinational from registered level. When full, no push is accepted even if pop occurs in the same cycle.
- i_valid = (level != 0). i_dat = mem[rp], combinational from registered state. Show-ahead: the head is visible whenever i_valid=1.
- Latency: a byte pushed at edge N into an empty FIFO gives i_valid=1 and i_dat=that byte after edge N. It is poppable at edge N+1.
- i_dat must hold stable while i_valid=1 and i_ready=0. A push never alters the head entry.
- level update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, both ptrs advance.
- hi_wat and empty are registered-state-derived, with no extra latency beyond level.
- flush = 1 at an edge: wp <= 0, rp <= 0, level <= 0. Any push or pop in that cycle is discarded; flush has priority.
- Reset (reset = 1 at an edge): wp = 0, rp = 0, level = 0. Therefore after reset t_ready=1, i_valid=0, empty=1, hi_wat=0 (HIWAT>=1).
  - i_dat after reset is don't-care. Memory contents are not reset.
- Reset mid-transfer discards all stored bytes. A byte partially shifted by fwuart_tx is that block's concern; this FIFO only guarantees it is clear on the next cycle.
- No overflow or underflow is possible by construction. Pushes while full and pops while empty are simply not handshakes.
- Order is strictly preserved; no byte is duplicated or lost except via reset or flush.

Test Plan:
- Reset then idle -> t_ready=1, i_valid=0, level=0, empty=1, hi_wat=0 for 10 cycles.
- Push 0x55 into empty FIFO with i_ready=0 -> next cycle i_valid=1, i_dat=0x55, level=1. Hold 5 cycles -> i_dat stays 0x55. Raise i_ready -> pop, level=0.
- Push 16 bytes 0x00..0x0F with i_ready=0 -> after 12th push hi_wat=1, after 16th t_ready=0, level=16. 17th t_valid is not accepted. Then drain -> 0x00..0x0F in order, empty=1 at end.
- Full FIFO with t_valid=1 and i_ready=1 on the same cycle -> only pop occurs, level 16->15. Next cycle push and pop together -> level stays 15, ptrs wrap correctly.
- Random-valid/random-ready stream of 1000 bytes through fwuart_tx/fwuart_rx back-to-back at 460800 baud -> rx output byte sequence matches push sequence exactly.
- flush asserted with level=7 while t_valid=1 and i_ready=1 -> next cycle level=0, i_valid=0. The next push 0xA5 emerges as the first popped byte.

Source files
------------

// File: rtl/fwuart_tx_fifo.sv
// Byte FIFO upstream of fwuart_tx: decouples bursty producers from the serial line.
// Latency: a byte pushed at edge N is visible on i_dat/i_valid right after edge N (show-ahead).
// Backpressure: t_ready drops when full (a same-cycle pop does not free a slot); i_ready stalls the head.
//
// Ports:
//   clock, reset       - system clock; synchronous active-high reset
//   t_dat/t_valid/t_ready - producer-side write interface
//   i_dat/i_valid/i_ready - consumer-side read interface to fwuart_tx
//   level, hi_wat, empty  - occupancy and watermark status from registered state
//   flush              - synchronous clear of contents; wins over push and pop
module fwuart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int HIWAT      = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] t_dat,
  input  logic                  t_valid,
  output logic                  t_ready,
  output logic [DATA_WIDTH-1:0] i_dat,
  output logic                  i_valid,
  input  logic                  i_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  hi_wat,
  output logic                  empty,
  input  logic                  flush
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_LVL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] HIWAT_LVL = (DEPTH_LOG2+1)'(HIWAT);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp;
  logic [DEPTH_LOG2-1:0] rp;
  logic                  push;
  logic                  pop;

  // Both readies come purely from the registered level, so a pop cannot
  // open a slot for a push in the same cycle when full.
  assign t_ready = (level != DEPTH_LVL);
  assign i_valid = (level != '0);
  assign i_dat   = mem[rp];
  assign empty   = (level == '0);
  assign hi_wat  = (level >= HIWAT_LVL);

  assign push = t_valid & t_ready;
  assign pop  = i_valid & i_ready;

  // Storage is deliberately not reset; the write never touches mem[rp]
  // while the FIFO is non-empty because wp != rp unless empty or full,
  // and no push is accepted when full.
  always_ff @(posedge clock) begin
    if (!reset && !flush && push) begin
      mem[wp] <= t_dat;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_fwuart_tx_fifo.sv
module tb_fwuart_tx_fifo;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] t_dat = 8'h00;
  logic       t_valid = 1'b0;
  logic       t_ready;
  logic [7:0] i_dat;
  logic       i_valid;
  logic       i_ready = 1'b0;
  logic [4:0] level;
  logic       hi_wat;
  logic       empty;
  logic       flush = 1'b0;

  fwuart_tx_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(4), .HIWAT(12)) dut (
    .clock   (clock),
    .reset   (reset),
    .t_dat   (t_dat),
    .t_valid (t_valid),
    .t_ready (t_ready),
    .i_dat   (i_dat),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .level   (level),
    .hi_wat  (hi_wat),
    .empty   (empty),
    .flush   (flush)
  );

  always #5 clock = ~clock;

  int         n_chk = 0;
  int         n_bad = 0;
  int         n_push = 0;
  int         n_pop = 0;
  logic [7:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: occupancy is the scoreboard size. Every negedge the
  // DUT status is compared with the model, then the handshakes that will
  // happen at the coming posedge are applied to the model.
  always @(negedge clock) begin
    int         sz;
    logic       m_push;
    logic       m_pop;
    logic [7:0] exp_b;
    sz = sb_q.size();
    if (reset) begin
      sb_q.delete();
    end else begin
      chk("mon_level",   level,   sz);
      chk("mon_t_ready", t_ready, (sz != 16));
      chk("mon_i_valid", i_valid, (sz != 0));
      chk("mon_empty",   empty,   (sz == 0));
      chk("mon_hi_wat",  hi_wat,  (sz >= 12));
      if (sz != 0) chk("mon_head", i_dat, sb_q[0]);
      m_push = t_valid && (sz != 16);
      m_pop  = i_ready && (sz != 0);
      if (flush) begin
        sb_q.delete();
      end else begin
        if (m_pop) begin
          exp_b = sb_q.pop_front();
          chk("pop_dat", i_dat, exp_b);
          n_pop++;
        end
        if (m_push) begin
          sb_q.push_back(t_dat);
          n_push++;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int budget;

    // Reset then idle
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    repeat (10) begin
      @(negedge clock);
      chk("idle_t_ready", t_ready, 1);
      chk("idle_i_valid", i_valid, 0);
      chk("idle_level",   level,   0);
      chk("idle_empty",   empty,   1);
      chk("idle_hi_wat",  hi_wat,  0);
    end
    cyc();

    // Single byte, held under stall, then popped
    t_dat = 8'h55; t_valid = 1'b1;
    cyc();
    t_valid = 1'b0;
    chk("one_i_valid", i_valid, 1);
    chk("one_i_dat",   i_dat,   8'h55);
    chk("one_level",   level,   1);
    repeat (5) cyc();
    chk("hold_i_dat",  i_dat,   8'h55);
    i_ready = 1'b1;
    cyc();
    i_ready = 1'b0;
    chk("one_pop_level", level, 0);

    // Fill to full
    for (int i = 0; i < 16; i++) begin
      t_dat = i[7:0]; t_valid = 1'b1;
      cyc();
      if (i == 10) chk("hw_below", hi_wat, 0);
      if (i == 11) chk("hw_at12",  hi_wat, 1);
      if (i == 14) chk("not_full_t_ready", t_ready, 1);
    end
    chk("full_t_ready", t_ready, 0);
    chk("full_level",   level,   16);
    t_dat = 8'hEE;
    cyc();
    chk("full_no_push", level, 16);

    // Full with push and pop offered: only the pop happens
    i_ready = 1'b1;
    cyc();
    chk("full_pop_only", level, 15);
    cyc();
    chk("push_pop_level", level, 15);
    t_valid = 1'b0;
    budget = 0;
    while (level != 0 && budget < 40) begin
      cyc();
      budget++;
    end
    chk("drain_timeout", (budget < 40), 1);
    chk("drain_empty", empty, 1);
    i_ready = 1'b0;

    // Flush at level 7 with push and pop offered
    for (int i = 0; i < 7; i++) begin
      t_dat = 8'h30 + i[7:0]; t_valid = 1'b1;
      cyc();
    end
    chk("pre_flush_level", level, 7);
    flush = 1'b1; i_ready = 1'b1; t_dat = 8'h99;
    cyc();
    flush = 1'b0; t_valid = 1'b0; i_ready = 1'b0;
    chk("flush_level",   level,   0);
    chk("flush_i_valid", i_valid, 0);
    t_dat = 8'hA5; t_valid = 1'b1;
    cyc();
    t_valid = 1'b0;
    chk("post_flush_head", i_dat, 8'hA5);
    i_ready = 1'b1;
    cyc();
    i_ready = 1'b0;
    chk("post_flush_empty", empty, 1);

    // Reset while holding data clears it on the next cycle
    for (int i = 0; i < 3; i++) begin
      t_dat = 8'hC0 + i[7:0]; t_valid = 1'b1;
      cyc();
    end
    t_valid = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_mid_level",   level,   0);
    chk("rst_mid_i_valid", i_valid, 0);

    // Random valid / random ready stream of 1000 bytes
    n_push = 0;
    budget = 0;
    while (n_push < 1000 && budget < 20000) begin
      t_valid = ($urandom_range(0, 3) != 0);
      t_dat   = 8'($urandom);
      i_ready = ($urandom_range(0, 2) != 0);
      cyc();
      budget++;
    end
    chk("rand_push_timeout", (n_push >= 1000), 1);
    t_valid = 1'b0;
    i_ready = 1'b1;
    budget = 0;
    while (sb_q.size() != 0 && budget < 40) begin
      cyc();
      budget++;
    end
    chk("rand_drain_timeout", sb_q.size(), 0);
    i_ready = 1'b0;
    @(negedge clock);
    chk("rand_end_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
